// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO stream reader.
//   DEFAULT_BUF_DEPTH : default number of buffer entries
//   rd_count_t        : type of the optional delivered-word counter
//   occ_width()       : bit width able to hold buf_count + inflight
package fifo_reader_pkg;

  localparam int DEFAULT_BUF_DEPTH = 3;

  typedef logic [31:0] rd_count_t;

  // Occupancy never exceeds depth, but the sum is formed before the compare,
  // so leave room for depth + 1.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Circular register buffer for the FIFO stream reader.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail
//   push_data  : word to store
//   pop        : remove the head word (caller guarantees count != 0)
//   head_data  : head word; when empty, the most recently popped word
//   count      : number of stored words, 0..BUF_DEPTH
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W    = $clog2(BUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [WIDTH-1:0] last;

  // Explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      last  <= '0;
    end else begin
      if (push) tail <= wrap_inc(tail);
      if (pop) begin
        head <= wrap_inc(head);
        last <= mem[head];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // Keeps the output steady once the buffer drains.
  assign head_data = (count != '0) ? mem[head] : last;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && count == CNT_W'(BUF_DEPTH)))
        else $error("fifo_reader_buf: overflow");
      assert (!(pop && count == '0))
        else $error("fifo_reader_buf: pop while empty");
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for synchronous_fifo: issues r_en, absorbs the FIFO's
// one-cycle registered read latency, and re-presents words as a
// valid/ready stream. r_en depends only on registered state and fifo_empty,
// never on m_ready.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   r_en          : FIFO read enable
//   fifo_data_out : FIFO read data, valid the cycle after an accepted r_en
//   fifo_empty    : FIFO empty flag
//   m_valid       : stream word available
//   m_ready       : consumer accepts the word
//   m_data        : stream word
//   rd_count      : delivered-word counter (only with FIFO_READER_STATS_EN)
// Optional feature macro: FIFO_READER_STATS_EN
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             r_en,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_STATS_EN
  ,
  output rd_count_t        rd_count
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = occ_width(BUF_DEPTH);

  if (BUF_DEPTH < 2 || BUF_DEPTH > 8) begin : g_bad_depth
    $error("fifo_stream_reader: BUF_DEPTH must be 2..8");
  end

  logic             active;
  logic             inflight;
  logic [CNT_W-1:0] buf_count;
  logic [OCC_W-1:0] occ;
  logic             pop;

  // active holds r_en low while in reset and releases it at the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      inflight <= 1'b0;
    end else begin
      active   <= 1'b1;
      inflight <= r_en;
    end
  end

  // Counting the in-flight word reserves its slot before it lands.
  assign occ     = OCC_W'(buf_count) + OCC_W'(inflight);
  assign r_en    = active && !fifo_empty && (occ < OCC_W'(BUF_DEPTH));
  assign m_valid = (buf_count != '0);
  assign pop     = m_valid && m_ready;

  fifo_reader_buf #(
    .WIDTH     (WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (m_data),
    .count     (buf_count)
  );

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_count <= '0;
    else if (pop) rd_count <= rd_count + 1'b1;
  end
`endif

endmodule
